// File: rtl/sram_axi_arbiter.sv
// Two-master AXI4 arbiter in front of a single SRAM controller port. It owns one
// whole transaction at a time (address, data beats, response) with round-robin grant.
module sram_axi_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 19,
  parameter int ID_WIDTH   = 10,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  aclk,
  input  logic                  resetn,

  // master 0
  input  logic [ID_WIDTH-1:0]   s0_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s0_axi_awaddr,
  input  logic [7:0]            s0_axi_awlen,
  input  logic [2:0]            s0_axi_awsize,
  input  logic [1:0]            s0_axi_awburst,
  input  logic                  s0_axi_awlock,
  input  logic [3:0]            s0_axi_awcache,
  input  logic [2:0]            s0_axi_awprot,
  input  logic                  s0_axi_awvalid,
  output logic                  s0_axi_awready,
  input  logic [DATA_WIDTH-1:0] s0_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s0_axi_wstrb,
  input  logic                  s0_axi_wlast,
  input  logic                  s0_axi_wvalid,
  output logic                  s0_axi_wready,
  output logic [ID_WIDTH-1:0]   s0_axi_bid,
  output logic [1:0]            s0_axi_bresp,
  output logic                  s0_axi_bvalid,
  input  logic                  s0_axi_bready,
  input  logic [ID_WIDTH-1:0]   s0_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s0_axi_araddr,
  input  logic [7:0]            s0_axi_arlen,
  input  logic [2:0]            s0_axi_arsize,
  input  logic [1:0]            s0_axi_arburst,
  input  logic                  s0_axi_arlock,
  input  logic [3:0]            s0_axi_arcache,
  input  logic [2:0]            s0_axi_arprot,
  input  logic                  s0_axi_arvalid,
  output logic                  s0_axi_arready,
  output logic [ID_WIDTH-1:0]   s0_axi_rid,
  output logic [DATA_WIDTH-1:0] s0_axi_rdata,
  output logic [1:0]            s0_axi_rresp,
  output logic                  s0_axi_rlast,
  output logic                  s0_axi_rvalid,
  input  logic                  s0_axi_rready,

  // master 1
  input  logic [ID_WIDTH-1:0]   s1_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s1_axi_awaddr,
  input  logic [7:0]            s1_axi_awlen,
  input  logic [2:0]            s1_axi_awsize,
  input  logic [1:0]            s1_axi_awburst,
  input  logic                  s1_axi_awlock,
  input  logic [3:0]            s1_axi_awcache,
  input  logic [2:0]            s1_axi_awprot,
  input  logic                  s1_axi_awvalid,
  output logic                  s1_axi_awready,
  input  logic [DATA_WIDTH-1:0] s1_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s1_axi_wstrb,
  input  logic                  s1_axi_wlast,
  input  logic                  s1_axi_wvalid,
  output logic                  s1_axi_wready,
  output logic [ID_WIDTH-1:0]   s1_axi_bid,
  output logic [1:0]            s1_axi_bresp,
  output logic                  s1_axi_bvalid,
  input  logic                  s1_axi_bready,
  input  logic [ID_WIDTH-1:0]   s1_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s1_axi_araddr,
  input  logic [7:0]            s1_axi_arlen,
  input  logic [2:0]            s1_axi_arsize,
  input  logic [1:0]            s1_axi_arburst,
  input  logic                  s1_axi_arlock,
  input  logic [3:0]            s1_axi_arcache,
  input  logic [2:0]            s1_axi_arprot,
  input  logic                  s1_axi_arvalid,
  output logic                  s1_axi_arready,
  output logic [ID_WIDTH-1:0]   s1_axi_rid,
  output logic [DATA_WIDTH-1:0] s1_axi_rdata,
  output logic [1:0]            s1_axi_rresp,
  output logic                  s1_axi_rlast,
  output logic                  s1_axi_rvalid,
  input  logic                  s1_axi_rready,

  // SRAM controller slave port
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_WRESP = 2'd2,
    ST_READ  = 2'd3
  } state_e;

  state_e state_q, state_d;
  logic   grant_q, grant_d;
  logic   last_grant_q, last_grant_d;
  logic   addr_done_q, addr_done_d;
  logic   drop_en_q, drop_en_d;

  logic in_write, in_wresp, in_read;
  logic aw_open, ar_open;
  logic sel_awvalid, sel_wvalid, sel_bready, sel_arvalid, sel_rready;
  logic req0, req1;
  logic aw_hs, ar_hs, w_last_hs, b_hs, r_last_hs;

  assign in_write = (state_q == ST_WRITE);
  assign in_wresp = (state_q == ST_WRESP);
  assign in_read  = (state_q == ST_READ);

  // AW stays open through WRESP so a write whose data finished first still gets its address out.
  assign aw_open = (in_write | in_wresp) & ~addr_done_q;
  assign ar_open = in_read & ~addr_done_q;

  assign sel_awvalid = grant_q ? s1_axi_awvalid : s0_axi_awvalid;
  assign sel_wvalid  = grant_q ? s1_axi_wvalid  : s0_axi_wvalid;
  assign sel_bready  = grant_q ? s1_axi_bready  : s0_axi_bready;
  assign sel_arvalid = grant_q ? s1_axi_arvalid : s0_axi_arvalid;
  assign sel_rready  = grant_q ? s1_axi_rready  : s0_axi_rready;

  // Write address / data toward the controller
  assign m_axi_awid    = grant_q ? s1_axi_awid    : s0_axi_awid;
  assign m_axi_awaddr  = grant_q ? s1_axi_awaddr  : s0_axi_awaddr;
  assign m_axi_awlen   = grant_q ? s1_axi_awlen   : s0_axi_awlen;
  assign m_axi_awsize  = grant_q ? s1_axi_awsize  : s0_axi_awsize;
  assign m_axi_awburst = grant_q ? s1_axi_awburst : s0_axi_awburst;
  assign m_axi_awlock  = grant_q ? s1_axi_awlock  : s0_axi_awlock;
  assign m_axi_awcache = grant_q ? s1_axi_awcache : s0_axi_awcache;
  assign m_axi_awprot  = grant_q ? s1_axi_awprot  : s0_axi_awprot;
  assign m_axi_awvalid = aw_open & sel_awvalid;
  assign s0_axi_awready = aw_open & ~grant_q & m_axi_awready;
  assign s1_axi_awready = aw_open &  grant_q & m_axi_awready;

  assign m_axi_wdata  = grant_q ? s1_axi_wdata : s0_axi_wdata;
  assign m_axi_wstrb  = grant_q ? s1_axi_wstrb : s0_axi_wstrb;
  assign m_axi_wlast  = grant_q ? s1_axi_wlast : s0_axi_wlast;
  assign m_axi_wvalid = in_write & sel_wvalid;
  assign s0_axi_wready = in_write & ~grant_q & m_axi_wready;
  assign s1_axi_wready = in_write &  grant_q & m_axi_wready;

  // Outside WRESP any B beat is a stray and is swallowed once out of reset.
  assign m_axi_bready  = in_wresp ? sel_bready : drop_en_q;
  assign s0_axi_bvalid = in_wresp & ~grant_q & m_axi_bvalid;
  assign s1_axi_bvalid = in_wresp &  grant_q & m_axi_bvalid;
  assign s0_axi_bid    = m_axi_bid;
  assign s1_axi_bid    = m_axi_bid;
  assign s0_axi_bresp  = m_axi_bresp;
  assign s1_axi_bresp  = m_axi_bresp;

  // Read address toward the controller
  assign m_axi_arid    = grant_q ? s1_axi_arid    : s0_axi_arid;
  assign m_axi_araddr  = grant_q ? s1_axi_araddr  : s0_axi_araddr;
  assign m_axi_arlen   = grant_q ? s1_axi_arlen   : s0_axi_arlen;
  assign m_axi_arsize  = grant_q ? s1_axi_arsize  : s0_axi_arsize;
  assign m_axi_arburst = grant_q ? s1_axi_arburst : s0_axi_arburst;
  assign m_axi_arlock  = grant_q ? s1_axi_arlock  : s0_axi_arlock;
  assign m_axi_arcache = grant_q ? s1_axi_arcache : s0_axi_arcache;
  assign m_axi_arprot  = grant_q ? s1_axi_arprot  : s0_axi_arprot;
  assign m_axi_arvalid = ar_open & sel_arvalid;
  assign s0_axi_arready = ar_open & ~grant_q & m_axi_arready;
  assign s1_axi_arready = ar_open &  grant_q & m_axi_arready;

  // Outside READ any R beat is a stray and is swallowed once out of reset.
  assign m_axi_rready  = in_read ? sel_rready : drop_en_q;
  assign s0_axi_rvalid = in_read & ~grant_q & m_axi_rvalid;
  assign s1_axi_rvalid = in_read &  grant_q & m_axi_rvalid;
  assign s0_axi_rid    = m_axi_rid;
  assign s1_axi_rid    = m_axi_rid;
  assign s0_axi_rdata  = m_axi_rdata;
  assign s1_axi_rdata  = m_axi_rdata;
  assign s0_axi_rresp  = m_axi_rresp;
  assign s1_axi_rresp  = m_axi_rresp;
  assign s0_axi_rlast  = m_axi_rlast;
  assign s1_axi_rlast  = m_axi_rlast;

  assign req0 = s0_axi_awvalid | s0_axi_arvalid;
  assign req1 = s1_axi_awvalid | s1_axi_arvalid;

  assign aw_hs     = m_axi_awvalid & m_axi_awready;
  assign ar_hs     = m_axi_arvalid & m_axi_arready;
  assign w_last_hs = m_axi_wvalid & m_axi_wready & m_axi_wlast;
  assign b_hs      = in_wresp & m_axi_bvalid & sel_bready;
  assign r_last_hs = in_read & m_axi_rvalid & sel_rready & m_axi_rlast;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_done_d  = addr_done_q;
    drop_en_d    = 1'b1;

    case (state_q)
      ST_IDLE: begin
        addr_done_d = 1'b0;
        if (req0 | req1) begin
          grant_d      = (req0 & req1) ? ~last_grant_q : req1;
          last_grant_d = grant_d;
          // Within a master, a pending write beats a pending read.
          if (grant_d ? s1_axi_awvalid : s0_axi_awvalid) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_WRITE: begin
        if (aw_hs)     addr_done_d = 1'b1;
        if (w_last_hs) state_d     = ST_WRESP;
      end
      ST_WRESP: begin
        if (aw_hs) addr_done_d = 1'b1;
        if (b_hs)  state_d     = ST_IDLE;
      end
      ST_READ: begin
        if (ar_hs)     addr_done_d = 1'b1;
        if (r_last_hs) state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      addr_done_q  <= 1'b0;
      drop_en_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_done_q  <= addr_done_d;
      drop_en_q    <= drop_en_d;
    end
  end

endmodule

// File: tb/tb_sram_axi_arbiter.sv
// Directed bench for sram_axi_arbiter: two scripted masters and a small
// behavioural SRAM controller whose read data is (araddr << 8) + beat.
module tb_sram_axi_arbiter;

  localparam int DW = 32;
  localparam int AW = 19;
  localparam int IW = 10;
  localparam int SW = DW / 8;

  logic aclk;
  logic resetn;

  logic [IW-1:0] s0_axi_awid, s1_axi_awid, s0_axi_arid, s1_axi_arid;
  logic [AW-1:0] s0_axi_awaddr, s1_axi_awaddr, s0_axi_araddr, s1_axi_araddr;
  logic [7:0]    s0_axi_awlen, s1_axi_awlen, s0_axi_arlen, s1_axi_arlen;
  logic [2:0]    s0_axi_awsize, s1_axi_awsize, s0_axi_arsize, s1_axi_arsize;
  logic [1:0]    s0_axi_awburst, s1_axi_awburst, s0_axi_arburst, s1_axi_arburst;
  logic          s0_axi_awlock, s1_axi_awlock, s0_axi_arlock, s1_axi_arlock;
  logic [3:0]    s0_axi_awcache, s1_axi_awcache, s0_axi_arcache, s1_axi_arcache;
  logic [2:0]    s0_axi_awprot, s1_axi_awprot, s0_axi_arprot, s1_axi_arprot;
  logic          s0_axi_awvalid, s1_axi_awvalid, s0_axi_arvalid, s1_axi_arvalid;
  logic          s0_axi_awready, s1_axi_awready, s0_axi_arready, s1_axi_arready;
  logic [DW-1:0] s0_axi_wdata, s1_axi_wdata;
  logic [SW-1:0] s0_axi_wstrb, s1_axi_wstrb;
  logic          s0_axi_wlast, s1_axi_wlast, s0_axi_wvalid, s1_axi_wvalid;
  logic          s0_axi_wready, s1_axi_wready;
  logic [IW-1:0] s0_axi_bid, s1_axi_bid;
  logic [1:0]    s0_axi_bresp, s1_axi_bresp;
  logic          s0_axi_bvalid, s1_axi_bvalid, s0_axi_bready, s1_axi_bready;
  logic [IW-1:0] s0_axi_rid, s1_axi_rid;
  logic [DW-1:0] s0_axi_rdata, s1_axi_rdata;
  logic [1:0]    s0_axi_rresp, s1_axi_rresp;
  logic          s0_axi_rlast, s1_axi_rlast, s0_axi_rvalid, s1_axi_rvalid;
  logic          s0_axi_rready, s1_axi_rready;

  logic [IW-1:0] m_axi_awid, m_axi_arid, m_axi_bid, m_axi_rid;
  logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
  logic [7:0]    m_axi_awlen, m_axi_arlen;
  logic [2:0]    m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
  logic [1:0]    m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
  logic          m_axi_awlock, m_axi_arlock;
  logic [3:0]    m_axi_awcache, m_axi_arcache;
  logic          m_axi_awvalid, m_axi_awready, m_axi_arvalid, m_axi_arready;
  logic [DW-1:0] m_axi_wdata, m_axi_rdata;
  logic [SW-1:0] m_axi_wstrb;
  logic          m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic          m_axi_bvalid, m_axi_bready;
  logic          m_axi_rlast, m_axi_rvalid, m_axi_rready;

  sram_axi_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .STRB_WIDTH(SW)
  ) dut (
    .aclk(aclk), .resetn(resetn),
    .s0_axi_awid(s0_axi_awid), .s0_axi_awaddr(s0_axi_awaddr), .s0_axi_awlen(s0_axi_awlen),
    .s0_axi_awsize(s0_axi_awsize), .s0_axi_awburst(s0_axi_awburst), .s0_axi_awlock(s0_axi_awlock),
    .s0_axi_awcache(s0_axi_awcache), .s0_axi_awprot(s0_axi_awprot), .s0_axi_awvalid(s0_axi_awvalid),
    .s0_axi_awready(s0_axi_awready),
    .s0_axi_wdata(s0_axi_wdata), .s0_axi_wstrb(s0_axi_wstrb), .s0_axi_wlast(s0_axi_wlast),
    .s0_axi_wvalid(s0_axi_wvalid), .s0_axi_wready(s0_axi_wready),
    .s0_axi_bid(s0_axi_bid), .s0_axi_bresp(s0_axi_bresp), .s0_axi_bvalid(s0_axi_bvalid),
    .s0_axi_bready(s0_axi_bready),
    .s0_axi_arid(s0_axi_arid), .s0_axi_araddr(s0_axi_araddr), .s0_axi_arlen(s0_axi_arlen),
    .s0_axi_arsize(s0_axi_arsize), .s0_axi_arburst(s0_axi_arburst), .s0_axi_arlock(s0_axi_arlock),
    .s0_axi_arcache(s0_axi_arcache), .s0_axi_arprot(s0_axi_arprot), .s0_axi_arvalid(s0_axi_arvalid),
    .s0_axi_arready(s0_axi_arready),
    .s0_axi_rid(s0_axi_rid), .s0_axi_rdata(s0_axi_rdata), .s0_axi_rresp(s0_axi_rresp),
    .s0_axi_rlast(s0_axi_rlast), .s0_axi_rvalid(s0_axi_rvalid), .s0_axi_rready(s0_axi_rready),
    .s1_axi_awid(s1_axi_awid), .s1_axi_awaddr(s1_axi_awaddr), .s1_axi_awlen(s1_axi_awlen),
    .s1_axi_awsize(s1_axi_awsize), .s1_axi_awburst(s1_axi_awburst), .s1_axi_awlock(s1_axi_awlock),
    .s1_axi_awcache(s1_axi_awcache), .s1_axi_awprot(s1_axi_awprot), .s1_axi_awvalid(s1_axi_awvalid),
    .s1_axi_awready(s1_axi_awready),
    .s1_axi_wdata(s1_axi_wdata), .s1_axi_wstrb(s1_axi_wstrb), .s1_axi_wlast(s1_axi_wlast),
    .s1_axi_wvalid(s1_axi_wvalid), .s1_axi_wready(s1_axi_wready),
    .s1_axi_bid(s1_axi_bid), .s1_axi_bresp(s1_axi_bresp), .s1_axi_bvalid(s1_axi_bvalid),
    .s1_axi_bready(s1_axi_bready),
    .s1_axi_arid(s1_axi_arid), .s1_axi_araddr(s1_axi_araddr), .s1_axi_arlen(s1_axi_arlen),
    .s1_axi_arsize(s1_axi_arsize), .s1_axi_arburst(s1_axi_arburst), .s1_axi_arlock(s1_axi_arlock),
    .s1_axi_arcache(s1_axi_arcache), .s1_axi_arprot(s1_axi_arprot), .s1_axi_arvalid(s1_axi_arvalid),
    .s1_axi_arready(s1_axi_arready),
    .s1_axi_rid(s1_axi_rid), .s1_axi_rdata(s1_axi_rdata), .s1_axi_rresp(s1_axi_rresp),
    .s1_axi_rlast(s1_axi_rlast), .s1_axi_rvalid(s1_axi_rvalid), .s1_axi_rready(s1_axi_rready),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Behavioural SRAM controller: one AW then its W beats then B; one AR then its R beats.
  logic          sl_aw_have, sl_b_pend, sl_r_active;
  logic [IW-1:0] sl_awid, sl_bid, sl_arid;
  logic [AW-1:0] sl_araddr;
  logic [7:0]    sl_arlen, sl_beat;
  int            aw_cnt = 0;
  int            w_cnt = 0;
  logic [DW-1:0] last_wdata;
  logic [SW-1:0] last_wstrb;

  assign m_axi_awready = !sl_aw_have && !sl_b_pend;
  assign m_axi_wready  = sl_aw_have;
  assign m_axi_bvalid  = sl_b_pend;
  assign m_axi_bid     = sl_bid;
  assign m_axi_bresp   = 2'b00;
  assign m_axi_arready = !sl_r_active;
  assign m_axi_rvalid  = sl_r_active;
  assign m_axi_rid     = sl_arid;
  assign m_axi_rdata   = (32'(sl_araddr) << 8) + 32'(sl_beat);
  assign m_axi_rresp   = 2'b00;
  assign m_axi_rlast   = (sl_beat == sl_arlen);

  always @(posedge aclk) begin
    if (!resetn) begin
      sl_aw_have  <= 1'b0;
      sl_b_pend   <= 1'b0;
      sl_r_active <= 1'b0;
      sl_beat     <= 8'd0;
    end else begin
      if (m_axi_awvalid && m_axi_awready) begin
        sl_aw_have <= 1'b1;
        sl_awid    <= m_axi_awid;
        aw_cnt     <= aw_cnt + 1;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        w_cnt      <= w_cnt + 1;
        last_wdata <= m_axi_wdata;
        last_wstrb <= m_axi_wstrb;
        if (m_axi_wlast) begin
          sl_aw_have <= 1'b0;
          sl_b_pend  <= 1'b1;
          sl_bid     <= sl_awid;
        end
      end
      if (m_axi_bvalid && m_axi_bready) sl_b_pend <= 1'b0;
      if (m_axi_arvalid && m_axi_arready) begin
        sl_r_active <= 1'b1;
        sl_arid     <= m_axi_arid;
        sl_araddr   <= m_axi_araddr;
        sl_arlen    <= m_axi_arlen;
        sl_beat     <= 8'd0;
      end
      if (m_axi_rvalid && m_axi_rready) begin
        if (m_axi_rlast) sl_r_active <= 1'b0;
        else             sl_beat     <= sl_beat + 8'd1;
      end
    end
  end

  // Handshake counters seen by each master.
  int s0_r_cnt = 0;
  int s1_r_cnt = 0;
  int s0_b_cnt = 0;
  always @(posedge aclk) begin
    if (s0_axi_rvalid && s0_axi_rready) s0_r_cnt <= s0_r_cnt + 1;
    if (s1_axi_rvalid && s1_axi_rready) s1_r_cnt <= s1_r_cnt + 1;
    if (s0_axi_bvalid && s0_axi_bready) s0_b_cnt <= s0_b_cnt + 1;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [14:0] handshake_vec();
    return {s0_axi_awready, s0_axi_wready, s0_axi_arready, s0_axi_bvalid, s0_axi_rvalid,
            s1_axi_awready, s1_axi_wready, s1_axi_arready, s1_axi_bvalid, s1_axi_rvalid,
            m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready};
  endfunction

  int aw_before, r0_before, r1_before, b0_before;

  initial begin
    resetn = 1'b0;
    {s0_axi_awid, s0_axi_awaddr, s0_axi_awlen, s0_axi_awlock, s0_axi_awvalid} = '0;
    {s0_axi_arid, s0_axi_araddr, s0_axi_arlen, s0_axi_arlock, s0_axi_arvalid} = '0;
    {s1_axi_awid, s1_axi_awaddr, s1_axi_awlen, s1_axi_awlock, s1_axi_awvalid} = '0;
    {s1_axi_arid, s1_axi_araddr, s1_axi_arlen, s1_axi_arlock, s1_axi_arvalid} = '0;
    s0_axi_awsize = 3'd2; s0_axi_awburst = 2'd1; s0_axi_awcache = 4'h3; s0_axi_awprot = 3'h2;
    s0_axi_arsize = 3'd2; s0_axi_arburst = 2'd1; s0_axi_arcache = 4'h3; s0_axi_arprot = 3'h2;
    s1_axi_awsize = 3'd2; s1_axi_awburst = 2'd1; s1_axi_awcache = 4'h0; s1_axi_awprot = 3'h0;
    s1_axi_arsize = 3'd2; s1_axi_arburst = 2'd1; s1_axi_arcache = 4'h0; s1_axi_arprot = 3'h0;
    {s0_axi_wdata, s0_axi_wstrb, s0_axi_wlast, s0_axi_wvalid} = '0;
    {s1_axi_wdata, s1_axi_wstrb, s1_axi_wlast, s1_axi_wvalid} = '0;
    s0_axi_bready = 1'b0; s1_axi_bready = 1'b0;
    s0_axi_rready = 1'b0; s1_axi_rready = 1'b0;

    // Reset state
    repeat (3) step();
    check("rst_handshakes", 64'(handshake_vec()), 64'h0);
    resetn = 1'b1;
    step(); step(); settle();
    check("idle_stray_bready", m_axi_bready, 1);
    check("idle_stray_rready", m_axi_rready, 1);

    // Both masters read at once: master 0 first, then master 1
    s0_axi_arid = 10'h011; s0_axi_araddr = 19'h100; s0_axi_arlen = 8'd0; s0_axi_arvalid = 1'b1;
    s1_axi_arid = 10'h022; s1_axi_araddr = 19'h200; s1_axi_arlen = 8'd0; s1_axi_arvalid = 1'b1;
    s0_axi_rready = 1'b1; s1_axi_rready = 1'b1;
    settle();
    check("a_idle_s0_arready", s0_axi_arready, 0);
    step(); settle();
    check("a_m_arvalid", m_axi_arvalid, 1);
    check("a_m_araddr", m_axi_araddr, 19'h100);
    check("a_m_arid", m_axi_arid, 10'h011);
    check("a_s0_arready", s0_axi_arready, 1);
    check("a_s1_arready_blocked", s1_axi_arready, 0);
    step(); s0_axi_arvalid = 1'b0; settle();
    check("a_s0_rvalid", s0_axi_rvalid, 1);
    check("a_s0_rdata", s0_axi_rdata, 32'h0001_0000);
    check("a_s0_rlast", s0_axi_rlast, 1);
    check("a_s0_rid", s0_axi_rid, 10'h011);
    check("a_s1_rvalid", s1_axi_rvalid, 0);
    check("a_s1_arready_burst", s1_axi_arready, 0);
    step(); settle();
    check("a_gap_s1_arready", s1_axi_arready, 0);
    check("a_gap_m_arvalid", m_axi_arvalid, 0);
    step(); settle();
    check("a_s1_arready", s1_axi_arready, 1);
    check("a_m_araddr_s1", m_axi_araddr, 19'h200);
    step(); s1_axi_arvalid = 1'b0; settle();
    check("a_s1_rdata", s1_axi_rdata, 32'h0002_0000);
    check("a_s1_rid", s1_axi_rid, 10'h022);
    check("a_s0_rvalid_off", s0_axi_rvalid, 0);
    step();

    // Master 0 4-beat write; master 1 read arrives mid-burst
    s0_axi_awid = 10'h155; s0_axi_awaddr = 19'h40; s0_axi_awlen = 8'd3; s0_axi_awvalid = 1'b1;
    s0_axi_wdata = 32'hAAAA_0000; s0_axi_wstrb = 4'hF; s0_axi_wlast = 1'b0; s0_axi_wvalid = 1'b1;
    s0_axi_bready = 1'b1;
    step(); settle();
    check("b_m_awvalid", m_axi_awvalid, 1);
    check("b_m_awaddr", m_axi_awaddr, 19'h40);
    check("b_m_awlen", m_axi_awlen, 3);
    check("b_m_awid", m_axi_awid, 10'h155);
    check("b_m_awcache", m_axi_awcache, 4'h3);
    check("b_m_awprot", m_axi_awprot, 3'h2);
    check("b_s0_awready", s0_axi_awready, 1);
    check("b_m_wvalid_early", m_axi_wvalid, 1);
    check("b_s0_wready_early", s0_axi_wready, 0);
    step(); s0_axi_awvalid = 1'b0; settle();
    check("b_s0_wready", s0_axi_wready, 1);
    check("b_m_awvalid_done", m_axi_awvalid, 0);
    for (int i = 0; i < 4; i++) begin
      s0_axi_wdata = 32'hAAAA_0000 + 32'(i);
      s0_axi_wlast = (i == 3);
      if (i == 2) begin
        s1_axi_arid = 10'h03A; s1_axi_araddr = 19'h300; s1_axi_arlen = 8'd1; s1_axi_arvalid = 1'b1;
      end
      settle();
      check("b_m_wdata", m_axi_wdata, 32'hAAAA_0000 + 32'(i));
      check("b_s1_arready", s1_axi_arready, 0);
      step();
    end
    s0_axi_wvalid = 1'b0; s0_axi_wlast = 1'b0; settle();
    check("b_w_beats", 64'(w_cnt), 4);
    check("b_last_wdata", last_wdata, 32'hAAAA_0003);
    check("b_s0_bvalid", s0_axi_bvalid, 1);
    check("b_s0_bid", s0_axi_bid, 10'h155);
    check("b_s0_bresp", s0_axi_bresp, 0);
    check("b_s1_bvalid", s1_axi_bvalid, 0);
    step(); settle();
    check("b_gap_s1_arready", s1_axi_arready, 0);
    check("b_gap_s0_bvalid", s0_axi_bvalid, 0);
    step(); settle();
    check("b_s1_arready", s1_axi_arready, 1);
    check("b_m_araddr", m_axi_araddr, 19'h300);
    step(); s1_axi_arvalid = 1'b0; settle();
    check("b_s1_rdata0", s1_axi_rdata, 32'h0003_0000);
    check("b_s1_rlast0", s1_axi_rlast, 0);
    step(); settle();
    check("b_s1_rdata1", s1_axi_rdata, 32'h0003_0001);
    check("b_s1_rlast1", s1_axi_rlast, 1);
    step();

    // Master 0 write and read together: write first, read next
    s0_axi_awid = 10'h0A1; s0_axi_awaddr = 19'h80; s0_axi_awlen = 8'd0; s0_axi_awvalid = 1'b1;
    s0_axi_arid = 10'h0B2; s0_axi_araddr = 19'h90; s0_axi_arlen = 8'd0; s0_axi_arvalid = 1'b1;
    s0_axi_wdata = 32'h1234_5678; s0_axi_wlast = 1'b1; s0_axi_wvalid = 1'b1;
    step(); settle();
    check("c_m_awvalid", m_axi_awvalid, 1);
    check("c_m_arvalid", m_axi_arvalid, 0);
    check("c_s0_arready", s0_axi_arready, 0);
    step(); s0_axi_awvalid = 1'b0; settle();
    check("c_s0_wready", s0_axi_wready, 1);
    step(); s0_axi_wvalid = 1'b0; s0_axi_wlast = 1'b0; settle();
    check("c_s0_bvalid", s0_axi_bvalid, 1);
    check("c_s0_bid", s0_axi_bid, 10'h0A1);
    step(); settle();
    check("c_gap_m_arvalid", m_axi_arvalid, 0);
    step(); settle();
    check("c_m_arvalid_rd", m_axi_arvalid, 1);
    check("c_m_araddr", m_axi_araddr, 19'h90);
    step(); s0_axi_arvalid = 1'b0; settle();
    check("c_s0_rdata", s0_axi_rdata, 32'h0000_9000);
    check("c_s0_rid", s0_axi_rid, 10'h0B2);
    step();

    // Master 0 8-beat read with a 5-cycle rready stall
    s0_axi_arid = 10'h077; s0_axi_araddr = 19'h10; s0_axi_arlen = 8'd7; s0_axi_arvalid = 1'b1;
    r0_before = s0_r_cnt; r1_before = s1_r_cnt;
    step(); step(); s0_axi_arvalid = 1'b0; settle();
    check("d_rdata0", s0_axi_rdata, 32'h0000_1000);
    step();
    s0_axi_rready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      check("d_stall_m_rready", m_axi_rready, 0);
      check("d_stall_rdata", s0_axi_rdata, 32'h0000_1001);
      check("d_stall_s1_rvalid", s1_axi_rvalid, 0);
      step();
    end
    s0_axi_rready = 1'b1;
    for (int b = 1; b < 8; b++) begin
      settle();
      check("d_rdata", s0_axi_rdata, 32'h0000_1000 + 32'(b));
      check("d_rlast", s0_axi_rlast, (b == 7));
      step();
    end
    settle();
    check("d_s0_beats", 64'(s0_r_cnt - r0_before), 8);
    check("d_s1_beats", 64'(s1_r_cnt - r1_before), 0);

    // W presented two cycles before AW
    s0_axi_wdata = 32'hCAFE_F00D; s0_axi_wstrb = 4'h3; s0_axi_wlast = 1'b1; s0_axi_wvalid = 1'b1;
    aw_before = aw_cnt; b0_before = s0_b_cnt;
    step(); step(); settle();
    check("e_idle_s0_wready", s0_axi_wready, 0);
    check("e_idle_m_wvalid", m_axi_wvalid, 0);
    s0_axi_awid = 10'h2C3; s0_axi_awaddr = 19'h44; s0_axi_awlen = 8'd0; s0_axi_awvalid = 1'b1;
    step(); settle();
    check("e_m_awvalid", m_axi_awvalid, 1);
    check("e_m_wvalid", m_axi_wvalid, 1);
    check("e_s0_wready_held", s0_axi_wready, 0);
    step(); settle();
    check("e_m_awvalid_blocked", m_axi_awvalid, 0);
    check("e_s0_awready_blocked", s0_axi_awready, 0);
    check("e_s0_wready", s0_axi_wready, 1);
    s0_axi_awvalid = 1'b0;
    step(); s0_axi_wvalid = 1'b0; s0_axi_wlast = 1'b0; settle();
    check("e_s0_bvalid", s0_axi_bvalid, 1);
    check("e_s0_bid", s0_axi_bid, 10'h2C3);
    check("e_aw_once", 64'(aw_cnt - aw_before), 1);
    check("e_wdata", last_wdata, 32'hCAFE_F00D);
    check("e_wstrb", last_wstrb, 4'h3);
    step(); step(); settle();
    check("e_single_b", 64'(s0_b_cnt - b0_before), 1);
    check("e_bvalid_off", s0_axi_bvalid, 0);

    // Reset during beat 2 of a 4-beat write
    s0_axi_awid = 10'h111; s0_axi_awaddr = 19'h60; s0_axi_awlen = 8'd3; s0_axi_awvalid = 1'b1;
    s0_axi_wdata = 32'hBEEF_0000; s0_axi_wlast = 1'b0; s0_axi_wvalid = 1'b1;
    step(); step(); s0_axi_awvalid = 1'b0;
    step(); s0_axi_wdata = 32'hBEEF_0001; settle();
    check("f_pre_rst_wready", s0_axi_wready, 1);
    resetn = 1'b0;
    step();
    check("f_rst_handshakes", 64'(handshake_vec()), 64'h0);
    s0_axi_wvalid = 1'b0; resetn = 1'b1;
    s0_axi_arid = 10'h005; s0_axi_araddr = 19'h500; s0_axi_arlen = 8'd0; s0_axi_arvalid = 1'b1;
    s1_axi_arid = 10'h006; s1_axi_araddr = 19'h600; s1_axi_arlen = 8'd0; s1_axi_arvalid = 1'b1;
    step(); settle();
    check("f_m_araddr", m_axi_araddr, 19'h500);
    check("f_s0_arready", s0_axi_arready, 1);
    check("f_s1_arready", s1_axi_arready, 0);
    step(); s0_axi_arvalid = 1'b0; settle();
    check("f_s0_rdata", s0_axi_rdata, 32'h0005_0000);
    step(); step(); settle();
    check("f_m_araddr_s1", m_axi_araddr, 19'h600);
    check("f_s1_arready", s1_axi_arready, 1);
    step(); s1_axi_arvalid = 1'b0; settle();
    check("f_s1_rdata", s1_axi_rdata, 32'h0006_0000);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
